shift_add_mul: RTL and testbench



---
 rtl/shift_add_mul.sv | 121 ++++++++++++
 tb/tb_shift_add_mul.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// Iterative 32x32 unsigned shift-and-add multiplier: low 32 product bits plus an exact overflow flag.
// The multiplicand advances through leftmove and partial sums go through a gate-level ripple adder.

module leftmove (
  input  logic [31:0] value,
  output logic [31:0] shifted
);
  assign shifted = {value[30:0], 1'b0};
endmodule

module gadder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum,
  output logic        carry
);
  logic [32:0] c;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign carry = c[32];
endmodule

module shift_add_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf
);
  // Handshake: start is sampled only in IDLE; the accepting edge captures a/b and raises busy.
  // done is a one-cycle pulse; product/ovf update on the edge entering DONE and hold until the next.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] m;
  logic [31:0] q;
  logic [31:0] p;
  logic        lost;
  logic        ov;

  logic [31:0] m_next;
  logic [31:0] sum;
  logic        carry;

  leftmove u_leftmove (
    .value   (m),
    .shifted (m_next)
  );

  gadder32 u_adder (
    .x     (p),
    .y     (m),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      p       <= '0;
      lost    <= 1'b0;
      ov      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            p     <= '0;
            lost  <= 1'b0;
            ov    <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (q != '0) begin
            // An add with a bit already shifted past bit 31 means the true product is >= 2^32.
            if (q[0]) begin
              p  <= sum;
              ov <= ov | carry | lost;
            end
            m    <= m_next;
            lost <= lost | m[31];
            q    <= {1'b0, q[31:1]};
          end else begin
            product <= p;
            ovf     <= ov;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: vector table plus hand-written ignore-start and reset-abort sequences.

module tb_shift_add_mul;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_product;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  shift_add_mul dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Launch one multiply and wait for done; all sampling happens on negedges.
  // inj_at >= 0 drives a one-cycle start with different operands that must be ignored.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input int inj_at,
                        output int lat, output int busy_cyc, output logic [31:0] prod_o,
                        output logic ovf_o);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      if (lat == inj_at) begin
        a = 32'd3; b = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy) busy_cyc++;
    prod_o = product;
    ovf_o  = ovf;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int inj_at);
    int          lat;
    int          busy_cyc;
    logic [31:0] prod_o;
    logic        ovf_o;
    run_op(v.a, v.b, inj_at, lat, busy_cyc, prod_o, ovf_o);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " product"}, prod_o, v.exp_product);
    chk({tag, " ovf"}, {31'd0, ovf_o}, {31'd0, v.exp_ovf});
    chk({tag, " busy_cycles"}, busy_cyc, v.exp_lat + 1);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " product_held"}, product, v.exp_product);
  endtask

  initial begin
    vec_t v;
    pass_cnt  = 0;
    total_cnt = 0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{32'd3,        32'd5,        32'd15,        1'b0, 4};
    vecs[1] = '{32'h12345678, 32'h0,        32'h0,         1'b0, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF,  1'b0, 2};
    vecs[3] = '{32'h80000000, 32'h2,        32'h0,         1'b1, 3};
    vecs[4] = '{32'h00010000, 32'h00010000, 32'h0,         1'b1, 18};
    vecs[5] = '{32'h60000000, 32'h3,        32'h20000000,  1'b1, 3};
    vecs[6] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,  1'b0, 17};
    vecs[7] = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000,  1'b0, 17};

    rst = 1'b1;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) check_vec($sformatf("vec%0d", i), vecs[i], -1);

    // Full-length op with an ignored start injected mid-run.
    v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33};
    check_vec("max_ignore_start", v, 10);

    // Reset abort mid-run: outputs clear immediately, no done.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort product", product, 32'd0);
    chk("abort ovf", {31'd0, ovf}, 32'd0);
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen_done = 1;
      end
      rst = 1'b0;
      repeat (35) begin
        @(negedge clk);
        if (done) seen_done = 1;
      end
      chk("abort no_done", seen_done, 0);
    end
    v = '{32'd7, 32'd6, 32'd42, 1'b0, 4};
    check_vec("after_abort", v, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
